// File: rtl/ipif_pkg.sv
// Shared definitions for the AXI4-Lite to IPIF register bridge.
package ipif_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // state      | meaning
    // IDLE       | no transaction; arbitrating AW+W against AR
    // WR_CE      | WrCE strobe cycle, Bus2IP_Data/BE valid
    // WR_RESP    | BVALID held until BREADY
    // RD_CE      | RdCE strobe cycle
    // RD_WAIT    | decode allowance; read slice captured at end of cycle
    // RD_RESP    | RVALID held until RREADY
    typedef enum logic [2:0] {
        IDLE,
        WR_CE,
        WR_RESP,
        RD_CE,
        RD_WAIT,
        RD_RESP
    } axil_state_t;

    // Byte-address bits below the register index.
    function automatic int ipif_addr_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/ipif_axil_slave.sv
// AXI4-Lite slave terminating register accesses into one-hot IPIF CE strobes.
module ipif_axil_slave
    import ipif_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 8,
    parameter int N_REG              = 2
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [N_REG-1:0]                  RdCE,
    output logic [N_REG-1:0]                  WrCE,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     Bus2IP_Data,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0]   Bus2IP_BE,
    input  logic [N_REG*C_S_AXI_DATA_WIDTH-1:0] IP2Bus_Data
);

    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int BW       = C_S_AXI_DATA_WIDTH / 8;
    localparam int ADDR_LSB = ipif_addr_lsb(C_S_AXI_DATA_WIDTH);
    localparam int IDX_W    = C_S_AXI_ADDR_WIDTH - ADDR_LSB;

    axil_state_t      r_state;
    axil_state_t      w_state_nxt;
    logic             r_prefer_rd;
    logic [IDX_W-1:0] r_idx;
    logic             r_err;
    logic [N_REG-1:0] r_rdce;
    logic [N_REG-1:0] r_wrce;
    logic             r_bvalid;
    logic             r_rvalid;
    logic [DW-1:0]    r_rdata;
    logic [DW-1:0]    r_b2ip_data;
    logic [BW-1:0]    r_b2ip_be;

    logic             w_wr_pend;
    logic             w_rd_pend;
    logic             w_grant_wr;
    logic             w_grant_rd;
    logic [IDX_W-1:0] w_idx_in;
    logic             w_in_range_in;
    logic [N_REG-1:0] w_onehot;
    logic [DW-1:0]    w_rd_slice;
    logic             w_unused_addr_lsbs;

    // Sub-word address bits carry no meaning for word-wide registers.
    assign w_unused_addr_lsbs = &{1'b0, S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

    assign w_wr_pend  = S_AXI_AWVALID & S_AXI_WVALID;
    assign w_rd_pend  = S_AXI_ARVALID;
    assign w_grant_rd = (r_state == IDLE) && w_rd_pend && (!w_wr_pend || r_prefer_rd);
    assign w_grant_wr = (r_state == IDLE) && w_wr_pend && (!w_rd_pend || !r_prefer_rd);

    assign S_AXI_AWREADY = w_grant_wr;
    assign S_AXI_WREADY  = w_grant_wr;
    assign S_AXI_ARREADY = w_grant_rd;

    assign w_idx_in      = w_grant_wr ? S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB]
                                      : S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
    assign w_in_range_in = (int'(w_idx_in) < N_REG);

    // One-hot decode of the incoming index; all-zero when out of range.
    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < N_REG; i++) begin
            w_onehot[i] = (int'(w_idx_in) == i);
        end
    end

    // Read mux over the flattened register view; out-of-range reads return 0.
    always_comb begin
        w_rd_slice = '0;
        for (int i = 0; i < N_REG; i++) begin
            if (int'(r_idx) == i) begin
                w_rd_slice = IP2Bus_Data[i*DW +: DW];
            end
        end
    end

    // State register.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_grant_wr) begin
                    w_state_nxt = WR_CE;
                end else if (w_grant_rd) begin
                    w_state_nxt = RD_CE;
                end
            end
            WR_CE:   w_state_nxt = WR_RESP;
            WR_RESP: if (S_AXI_BREADY) w_state_nxt = IDLE;
            RD_CE:   w_state_nxt = RD_WAIT;
            RD_WAIT: w_state_nxt = RD_RESP;
            RD_RESP: if (S_AXI_RREADY) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Registered strobes, valids, captured transaction data and arbitration flag.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_prefer_rd <= 1'b1;
            r_idx       <= '0;
            r_err       <= 1'b0;
            r_rdce      <= '0;
            r_wrce      <= '0;
            r_bvalid    <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rdata     <= '0;
            r_b2ip_data <= '0;
            r_b2ip_be   <= '0;
        end else begin
            r_wrce   <= w_grant_wr ? w_onehot : '0;
            r_rdce   <= w_grant_rd ? w_onehot : '0;
            r_bvalid <= (w_state_nxt == WR_RESP);
            r_rvalid <= (w_state_nxt == RD_RESP);
            if (w_grant_wr || w_grant_rd) begin
                r_idx <= w_idx_in;
                r_err <= !w_in_range_in;
            end
            if (w_grant_wr) begin
                r_b2ip_data <= S_AXI_WDATA;
                r_b2ip_be   <= S_AXI_WSTRB;
            end
            if (r_state == RD_WAIT) begin
                r_rdata <= w_rd_slice;
            end
            // Only a real collision flips priority, so uncontested traffic
            // never starves the other direction at the next collision.
            if ((r_state == IDLE) && w_wr_pend && w_rd_pend) begin
                r_prefer_rd <= !r_prefer_rd;
            end
        end
    end

    assign S_AXI_BVALID = r_bvalid;
    assign S_AXI_BRESP  = (r_bvalid && r_err) ? RESP_SLVERR : RESP_OKAY;
    assign S_AXI_RVALID = r_rvalid;
    assign S_AXI_RRESP  = (r_rvalid && r_err) ? RESP_SLVERR : RESP_OKAY;
    assign S_AXI_RDATA  = r_rdata;
    assign RdCE         = r_rdce;
    assign WrCE         = r_wrce;
    assign Bus2IP_Data  = r_b2ip_data;
    assign Bus2IP_BE    = r_b2ip_be;

endmodule

// File: tb/tb_ipif_axil_slave.sv
// Self-checking bench for ipif_axil_slave: vector table, corner sequences, response scoreboard.
module tb_ipif_axil_slave;
    import ipif_pkg::*;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NR = 2;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [AW-1:0]     awaddr = '0;
    logic              awvalid = 1'b0;
    logic              awready;
    logic [DW-1:0]     wdata = '0;
    logic [DW/8-1:0]   wstrb = '0;
    logic              wvalid = 1'b0;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready = 1'b1;
    logic [AW-1:0]     araddr = '0;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [DW-1:0]     rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready = 1'b1;
    logic [NR-1:0]     rdce;
    logic [NR-1:0]     wrce;
    logic [DW-1:0]     b2ip_data;
    logic [DW/8-1:0]   b2ip_be;
    logic [NR*DW-1:0]  ip_data = {32'h12345678, 32'hCAFEF00D};

    always #5 clk = ~clk;

    ipif_axil_slave #(
        .C_S_AXI_DATA_WIDTH(DW),
        .C_S_AXI_ADDR_WIDTH(AW),
        .N_REG(NR)
    ) dut (
        .S_AXI_ACLK(clk),       .S_AXI_ARESETN(rstn),
        .S_AXI_AWADDR(awaddr),  .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata),    .S_AXI_WSTRB(wstrb),     .S_AXI_WVALID(wvalid),
        .S_AXI_WREADY(wready),  .S_AXI_BRESP(bresp),     .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready),  .S_AXI_ARADDR(araddr),   .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready), .S_AXI_RDATA(rdata),    .S_AXI_RRESP(rresp),
        .S_AXI_RVALID(rvalid),  .S_AXI_RREADY(rready),   .RdCE(rdce),
        .WrCE(wrce),            .Bus2IP_Data(b2ip_data), .Bus2IP_BE(b2ip_be),
        .IP2Bus_Data(ip_data)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          is_rd;
        logic [1:0]  resp;
        logic [31:0] data;
    } sb_t;
    sb_t sb_q[$];
    sb_t mon_e;

    typedef struct {
        bit          is_rd;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [1:0]  exp_ce;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
    } vec_t;
    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Response scoreboard and CE one-hot monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if ((rdce | wrce) != '0) begin
            check("ce_onehot", 64'($countones(rdce | wrce)), 64'd1);
        end
        if (rstn && bvalid && bready) begin
            if (sb_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL sb_unexpected_b: got bresp %0h expected no response", bresp);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_b_kind", 64'(mon_e.is_rd), 64'd0);
                check("sb_bresp", 64'(bresp), 64'(mon_e.resp));
            end
        end
        if (rstn && rvalid && rready) begin
            if (sb_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL sb_unexpected_r: got rdata %0h expected no response", rdata);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_r_kind", 64'(mon_e.is_rd), 64'd1);
                check("sb_rresp", 64'(rresp), 64'(mon_e.resp));
                check("sb_rdata", 64'(rdata), 64'(mon_e.data));
            end
        end
    end

    task automatic wait_ready(input bit rd, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (n < 40) begin
            if (rd ? arready : (awready && wready)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk); #1;
            n++;
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL accept_timeout: got no ready after %0d cycles expected handshake", n);
        end
    endtask

    task automatic finish_write(input logic [31:0] d, input logic [3:0] s,
                                input logic [1:0] exp_ce, input logic [1:0] exp_resp);
        bit ok;
        wait_ready(1'b0, ok);
        if (!ok) begin
            awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        sb_q.push_back(sb_t'{1'b0, exp_resp, 32'h0});
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        check("wrce", 64'(wrce), 64'(exp_ce));
        if (exp_ce != '0) begin
            check("b2ip_data", 64'(b2ip_data), 64'(d));
            check("b2ip_be", 64'(b2ip_be), 64'(s));
        end
        check("bvalid_early", 64'(bvalid), 64'd0);
        @(negedge clk);
        check("bvalid", 64'(bvalid), 64'd1);
        check("wrce_pulse", 64'(wrce), 64'd0);
    endtask

    task automatic finish_read(input logic [1:0] exp_ce, input logic [31:0] exp_d,
                               input logic [1:0] exp_resp);
        bit ok;
        wait_ready(1'b1, ok);
        if (!ok) begin
            arvalid = 1'b0;
            return;
        end
        sb_q.push_back(sb_t'{1'b1, exp_resp, exp_d});
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        check("rdce", 64'(rdce), 64'(exp_ce));
        check("rvalid_t1", 64'(rvalid), 64'd0);
        @(negedge clk);
        check("rdce_pulse", 64'(rdce), 64'd0);
        check("rvalid_t2", 64'(rvalid), 64'd0);
        @(negedge clk);
        check("rvalid_t3", 64'(rvalid), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        vecs[0] = '{1'b0, 8'h04, 32'hDEADBEEF, 4'hF, 2'b10, 32'h0,        RESP_OKAY};
        vecs[1] = '{1'b0, 8'h00, 32'h11223344, 4'h3, 2'b01, 32'h0,        RESP_OKAY};
        vecs[2] = '{1'b1, 8'h00, 32'h0,        4'h0, 2'b01, 32'hCAFEF00D, RESP_OKAY};
        vecs[3] = '{1'b1, 8'h04, 32'h0,        4'h0, 2'b10, 32'h12345678, RESP_OKAY};
        vecs[4] = '{1'b1, 8'h08, 32'h0,        4'h0, 2'b00, 32'h0,        RESP_SLVERR};
        vecs[5] = '{1'b0, 8'h0C, 32'h55AA55AA, 4'hF, 2'b00, 32'h0,        RESP_SLVERR};
        vecs[6] = '{1'b1, 8'h07, 32'h0,        4'h0, 2'b10, 32'h12345678, RESP_OKAY};
        vecs[7] = '{1'b0, 8'h02, 32'h0F0F0F0F, 4'h8, 2'b01, 32'h0,        RESP_OKAY};
        vecs[8] = '{1'b1, 8'hFC, 32'h0,        4'h0, 2'b00, 32'h0,        RESP_SLVERR};

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_bvalid", 64'(bvalid), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_ce", 64'({rdce, wrce}), 64'd0);
        check("rst_b2ip", 64'({b2ip_data, b2ip_be}), 64'd0);
        check("rst_rdata", 64'({rdata, rresp, bresp}), 64'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Collision from reset: read first, then write
        araddr = 8'h00; arvalid = 1'b1;
        awaddr = 8'h04; wdata = 32'hA5A5A5A5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        check("coll1_arready", 64'(arready), 64'd1);
        check("coll1_awready", 64'(awready), 64'd0);
        finish_read(2'b01, 32'hCAFEF00D, RESP_OKAY);
        finish_write(32'hA5A5A5A5, 4'hF, 2'b10, RESP_OKAY);

        // Second collision: write first
        araddr = 8'h04; arvalid = 1'b1;
        awaddr = 8'h00; wdata = 32'h0BADCAFE; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk); #1;
        check("coll2_awready", 64'(awready), 64'd1);
        check("coll2_arready", 64'(arready), 64'd0);
        finish_write(32'h0BADCAFE, 4'h1, 2'b01, RESP_OKAY);
        finish_read(2'b10, 32'h12345678, RESP_OKAY);

        // AW alone is not accepted until W arrives
        @(negedge clk);
        awaddr = 8'h04; awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("aw_alone_ready", 64'({awready, wready}), 64'd0);
            @(negedge clk);
        end
        wdata = 32'h600DF00D; wstrb = 4'hC; wvalid = 1'b1;
        #1;
        check("aw_w_ready", 64'(awready), 64'd1);
        finish_write(32'h600DF00D, 4'hC, 2'b10, RESP_OKAY);

        // Vector table
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].is_rd) begin
                araddr = vecs[i].addr; arvalid = 1'b1;
                #1;
                finish_read(vecs[i].exp_ce, vecs[i].exp_rdata, vecs[i].exp_resp);
            end else begin
                awaddr = vecs[i].addr; wdata = vecs[i].wdata; wstrb = vecs[i].strb;
                awvalid = 1'b1; wvalid = 1'b1;
                #1;
                finish_write(vecs[i].wdata, vecs[i].strb, vecs[i].exp_ce, vecs[i].exp_resp);
            end
        end

        // RREADY stall: RVALID/RDATA hold, no new read accepted
        @(negedge clk);
        rready = 1'b0;
        araddr = 8'h04; arvalid = 1'b1;
        #1;
        finish_read(2'b10, 32'h12345678, RESP_OKAY);
        #1;
        ip_data = {32'hFFFF0000, 32'h00000000};
        araddr = 8'h00; arvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_rvalid", 64'(rvalid), 64'd1);
            check("stall_rdata", 64'(rdata), 64'h12345678);
            check("stall_arready", 64'(arready), 64'd0);
        end
        arvalid = 1'b0;
        @(posedge clk); #1;
        rready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ip_data = {32'h12345678, 32'hCAFEF00D};

        // Reset during RD_WAIT abandons the read
        araddr = 8'h00; arvalid = 1'b1;
        #1;
        wait_ready(1'b1, ok);
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        check("abort_rdce", 64'(rdce), 64'd1);
        @(negedge clk); #1;
        rstn = 1'b0;
        #1;
        check("abort_rvalid", 64'(rvalid), 64'd0);
        check("abort_ce", 64'({rdce, wrce}), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_resp", 64'({rvalid, bvalid}), 64'd0);
        end
        araddr = 8'h00; arvalid = 1'b1;
        #1;
        finish_read(2'b01, 32'hCAFEF00D, RESP_OKAY);
        @(negedge clk);

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
